// File: rtl/perf_cnt_pkg.sv
// perf_cnt_pkg: shared constants for the performance counter bank.
//   NCH_MAX / CW_MAX : upper legal limits for channel count and counter width
//   CH_*             : conventional channel assignments used by cpu_top
//   sel_width()      : read-select width for a given channel count (min 1)
package perf_cnt_pkg;

  localparam int NCH_MAX = 16;
  localparam int CW_MAX  = 32;

  localparam int CH_HIT   = 0;
  localparam int CH_TOT   = 1;
  localparam int CH_STALL = 2;
  localparam int CH_FLUSH = 3;

  // A single-channel bank still needs a 1-bit select so rd_sel=1 can
  // address the "out of range" read that returns 0.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/perf_cnt_cell.sv
// perf_cnt_cell: one event counter channel with sticky overflow and shadow.
//   clk    : CPU clock
//   rst    : synchronous active-high reset
//   en_inc : count one event this cycle (already gated by global enable)
//   clr    : clear counter and overflow flag
//   snap   : copy the pre-edge counter value into the shadow register
//   cnt    : live counter value
//   shadow : last snapshot value
//   ovf    : sticky overflow flag
module perf_cnt_cell #(
  parameter int CW  = 32,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_inc,
  input  logic          clr,
  input  logic          snap,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] shadow,
  output logic          ovf
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_shadow;
  logic          r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      // Shadow sees the value before this edge's clear/increment, which
      // makes snap+clr an atomic read-and-clear.
      if (snap) begin
        r_shadow <= r_cnt;
      end
      if (clr) begin
        // Clear wins over an overflow in the same cycle.
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (en_inc) begin
        if (r_cnt == CNT_MAX) begin
          r_cnt <= (SAT != 0) ? CNT_MAX : '0;
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign cnt    = r_cnt;
  assign shadow = r_shadow;
  assign ovf    = r_ovf;

endmodule

// File: rtl/perf_cnt_bank.sv
// perf_cnt_bank: NCH event counters with snapshot and indexed read port.
//   clk       : CPU clock
//   rst       : synchronous active-high reset
//   en        : global count enable (blocks increments only)
//   inc       : per-channel event strobes
//   clr       : clear all counters and overflow flags
//   snap      : copy all live counters into shadows, bump snap_cnt
//   rd_sel    : channel index for the read port
//   rd_data   : registered shadow value of rd_sel (0 if rd_sel >= NCH)
//   live_data : registered live value of rd_sel (0 if rd_sel >= NCH)
//   ovf       : sticky per-channel overflow flags
//   snap_cnt  : snapshots taken, wraps at 255
// Legal ranges: NCH 1..NCH_MAX, CW 8..CW_MAX. SELW is derived from NCH.
module perf_cnt_bank
  import perf_cnt_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CW   = 32,
  parameter int SAT  = 1,
  localparam int SELW = sel_width(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NCH-1:0]  inc,
  input  logic            clr,
  input  logic            snap,
  input  logic [SELW-1:0] rd_sel,
  output logic [CW-1:0]   rd_data,
  output logic [CW-1:0]   live_data,
  output logic [NCH-1:0]  ovf,
  output logic [7:0]      snap_cnt
);

  logic [CW-1:0]  w_cnt    [NCH];
  logic [CW-1:0]  w_shadow [NCH];
  logic [NCH-1:0] w_ovf;
  logic [CW-1:0]  w_live_sel;
  logic [CW-1:0]  w_shad_sel;

  logic [CW-1:0]  r_rd_data;
  logic [CW-1:0]  r_live_data;
  logic [7:0]     r_snap_cnt;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cell
    perf_cnt_cell #(
      .CW  (CW),
      .SAT (SAT)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en_inc (en & inc[gi]),
      .clr    (clr),
      .snap   (snap),
      .cnt    (w_cnt[gi]),
      .shadow (w_shadow[gi]),
      .ovf    (w_ovf[gi])
    );
  end

  // Compare-based mux so an out-of-range rd_sel falls through to 0
  // without indexing past the array.
  always_comb begin
    w_live_sel = '0;
    w_shad_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == SELW'(i)) begin
        w_live_sel = w_cnt[i];
        // A snap at this same edge is visible on rd_data straight away.
        w_shad_sel = snap ? w_cnt[i] : w_shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data   <= '0;
      r_live_data <= '0;
      r_snap_cnt  <= '0;
    end else begin
      r_rd_data   <= w_shad_sel;
      r_live_data <= w_live_sel;
      if (snap) begin
        r_snap_cnt <= r_snap_cnt + 8'd1;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign live_data = r_live_data;
  assign ovf       = w_ovf;
  assign snap_cnt  = r_snap_cnt;

endmodule

// File: tb/tb_perf_cnt_bank.sv
// Directed bench for perf_cnt_bank. Four instances share one stimulus:
//   u_a : NCH=4, CW=32, SAT=1 (default build)
//   u_s : NCH=4, CW=8,  SAT=1 (saturating)
//   u_w : NCH=4, CW=8,  SAT=0 (wrapping)
//   u_c : NCH=3, CW=8,  SAT=1 (non-power-of-two bank)
module tb_perf_cnt_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] inc;
  logic       clr;
  logic       snap;
  logic [1:0] rd_sel;

  logic [31:0] a_rd, a_live;
  logic [3:0]  a_ovf;
  logic [7:0]  a_sc;
  logic [7:0]  s_rd, s_live;
  logic [3:0]  s_ovf;
  logic [7:0]  s_sc;
  logic [7:0]  w_rd, w_live;
  logic [3:0]  w_ovf;
  logic [7:0]  w_sc;
  logic [7:0]  c_rd, c_live;
  logic [2:0]  c_ovf;
  logic [7:0]  c_sc;

  int n_total = 0;
  int n_pass  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  perf_cnt_bank #(.NCH(4), .CW(32), .SAT(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_data(a_rd), .live_data(a_live), .ovf(a_ovf), .snap_cnt(a_sc)
  );
  perf_cnt_bank #(.NCH(4), .CW(8), .SAT(1)) u_s (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_data(s_rd), .live_data(s_live), .ovf(s_ovf), .snap_cnt(s_sc)
  );
  perf_cnt_bank #(.NCH(4), .CW(8), .SAT(0)) u_w (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_data(w_rd), .live_data(w_live), .ovf(w_ovf), .snap_cnt(w_sc)
  );
  perf_cnt_bank #(.NCH(3), .CW(8), .SAT(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .inc(inc[2:0]), .clr(clr), .snap(snap),
    .rd_sel(rd_sel), .rd_data(c_rd), .live_data(c_live), .ovf(c_ovf), .snap_cnt(c_sc)
  );

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; en = 1'b0; inc = 4'b0000; clr = 1'b0; snap = 1'b0; rd_sel = 2'd0;

    // Reset held 2 cycles, then idle.
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_a_rd",   a_rd,   32'd0);
    chk("rst_a_live", a_live, 32'd0);
    chk("rst_a_ovf",  32'(a_ovf), 32'd0);
    chk("rst_a_sc",   32'(a_sc),  32'd0);
    chk("rst_c_live", 32'(c_live), 32'd0);

    // 10 events on every channel, snapshot, then read each channel.
    en = 1'b1; inc = 4'b1111;
    tick(10);
    inc = 4'b0000; snap = 1'b1;
    tick(1);
    snap = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_sel = 2'(k);
      tick(1);
      chk($sformatf("snap10_a_rd%0d", k),   a_rd,   32'd10);
      chk($sformatf("snap10_a_live%0d", k), a_live, 32'd10);
      chk($sformatf("snap10_c_rd%0d", k),   32'(c_rd),   (k < 3) ? 32'd10 : 32'd0);
      chk($sformatf("snap10_c_live%0d", k), 32'(c_live), (k < 3) ? 32'd10 : 32'd0);
    end
    chk("snap10_a_sc", 32'(a_sc), 32'd1);
    chk("snap10_s_ovf", 32'(s_ovf), 32'd0);

    // Clear: ovf drops at once, live_data one cycle later.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_a_ovf", 32'(a_ovf), 32'd0);
    tick(1);
    chk("clr_a_live3", a_live, 32'd0);

    // Saturation / wrap: 300 events on channel 0.
    rd_sel = 2'd0; inc = 4'b0001;
    tick(300);
    inc = 4'b0000;
    tick(1);
    chk("sat_s_live", 32'(s_live), 32'd255);
    chk("sat_s_ovf",  32'(s_ovf),  32'b0001);
    chk("sat_w_live", 32'(w_live), 32'd44);
    chk("sat_w_ovf",  32'(w_ovf),  32'b0001);
    chk("sat_a_live", a_live, 32'd300);
    chk("sat_a_ovf",  32'(a_ovf), 32'd0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    chk("satclr_s_live", 32'(s_live), 32'd0);
    chk("satclr_s_ovf",  32'(s_ovf),  32'd0);

    // Wrap: 257 events on channel 1, flag stays set while idle.
    rd_sel = 2'd1; inc = 4'b0010;
    tick(257);
    inc = 4'b0000;
    tick(1);
    chk("wrap_w_live", 32'(w_live), 32'd1);
    chk("wrap_w_ovf",  32'(w_ovf),  32'b0010);
    chk("wrap_s_live", 32'(s_live), 32'd255);
    tick(50);
    chk("wrap_w_ovf_sticky",  32'(w_ovf),  32'b0010);
    chk("wrap_w_live_sticky", 32'(w_live), 32'd1);

    // Read-and-clear on channel 2 at 37 with a coincident event.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    rd_sel = 2'd2; inc = 4'b0100;
    tick(37);
    snap = 1'b1; clr = 1'b1;
    tick(1);
    snap = 1'b0; clr = 1'b0; inc = 4'b0000;
    chk("rac_a_rd",   a_rd,   32'd37);
    chk("rac_a_live", a_live, 32'd37);
    tick(1);
    chk("rac_a_live_cleared", a_live, 32'd0);
    chk("rac_a_rd_hold",      a_rd,   32'd37);
    chk("rac_a_sc",           32'(a_sc), 32'd2);
    chk("rac_w_ovf",          32'(w_ovf), 32'd0);

    // Gating: bring channel 2 to 5, then en=0 with all strobes high.
    inc = 4'b0100;
    tick(5);
    en = 1'b0; inc = 4'b1111;
    tick(10);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    tick(9);
    chk("gate_a_live2", a_live, 32'd5);
    chk("gate_a_rd2",   a_rd,   32'd5);
    chk("gate_a_sc",    32'(a_sc), 32'd3);
    rd_sel = 2'd0;
    tick(1);
    chk("gate_a_live0", a_live, 32'd0);
    chk("gate_a_rd0",   a_rd,   32'd0);

    // Mid-count reset on the 3-channel bank at 123.
    inc = 4'b0000; en = 1'b1; clr = 1'b1;
    tick(1);
    clr = 1'b0; inc = 4'b1111;
    tick(123);
    inc = 4'b0000;
    tick(1);
    chk("mid_c_live", 32'(c_live), 32'd123);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_c_live_rst", 32'(c_live), 32'd0);
    chk("mid_c_rd_rst",   32'(c_rd),   32'd0);
    chk("mid_c_ovf_rst",  32'(c_ovf),  32'd0);
    chk("mid_c_sc_rst",   32'(c_sc),   32'd0);
    tick(1);
    chk("mid_c_live_zero", 32'(c_live), 32'd0);
    inc = 4'b0001;
    tick(3);
    inc = 4'b0000;
    tick(1);
    chk("mid_c_resume", 32'(c_live), 32'd3);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
